// File: rtl/cpu_ctrl_pkg.sv
// ============================================================================
// Module      : cpu_ctrl_pkg
// Description : Shared control definitions for the MiniRiscV multi-cycle core:
//               sequencer states, instruction classes, opcode constants,
//               ALU op codes, write-back selects and trap cause codes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CLS_NONE = 3'd0,
        CLS_R    = 3'd1,
        CLS_I    = 3'd2,
        CLS_LD   = 3'd3,
        CLS_ST   = 3'd4,
        CLS_BR   = 3'd5,
        CLS_JAL  = 3'd6
    } instr_class_t;

    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [6:0] OPC_LD  = 7'b0000011;
    localparam logic [6:0] OPC_ST  = 7'b0100011;
    localparam logic [6:0] OPC_BR  = 7'b1100011;
    localparam logic [6:0] OPC_JAL = 7'b1101111;

    localparam logic [1:0] ALUOP_LDST = 2'b00;
    localparam logic [1:0] ALUOP_BR   = 2'b01;
    localparam logic [1:0] ALUOP_R    = 2'b10;
    localparam logic [1:0] ALUOP_I    = 2'b11;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;

    localparam logic [1:0] TRAP_NONE    = 2'b00;
    localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
    localparam logic [1:0] TRAP_IMEM_TO = 2'b10;
    localparam logic [1:0] TRAP_DMEM_TO = 2'b11;

    // ALU operation selected for an instruction class (JAL computes PC+imm as ld/st add)
    function automatic logic [1:0] alu_op_of(input instr_class_t cls);
        case (cls)
            CLS_R:   alu_op_of = ALUOP_R;
            CLS_I:   alu_op_of = ALUOP_I;
            CLS_BR:  alu_op_of = ALUOP_BR;
            default: alu_op_of = ALUOP_LDST;
        endcase
    endfunction

    // ALU B operand comes from the immediate for everything but R-type and branches
    function automatic logic alu_src_of(input instr_class_t cls);
        case (cls)
            CLS_I, CLS_LD, CLS_ST, CLS_JAL: alu_src_of = 1'b1;
            default:                        alu_src_of = 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/opcode_classifier.sv
// ============================================================================
// Module      : opcode_classifier
// Description : Combinational opcode decoder; maps instr[6:0] onto an
//               instruction class and flags anything unrecognised as illegal.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module opcode_classifier
    import cpu_ctrl_pkg::*;
(
    input  logic [6:0]   opcode,
    output instr_class_t cls,
    output logic         illegal
);

    // Opcode lookup; unknown encodings leave the class cleared and raise illegal
    always_comb begin
        cls     = CLS_NONE;
        illegal = 1'b0;
        case (opcode)
            OPC_R:   cls = CLS_R;
            OPC_I:   cls = CLS_I;
            OPC_LD:  cls = CLS_LD;
            OPC_ST:  cls = CLS_ST;
            OPC_BR:  cls = CLS_BR;
            OPC_JAL: cls = CLS_JAL;
            default: illegal = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/cpu_multicycle_sequencer.sv
// ============================================================================
// Module      : cpu_multicycle_sequencer
// Description : Multi-cycle control FSM for the MiniRiscV core. Sequences
//               FETCH/DECODE/EXEC/MEM/WB around the registered ALU, drives
//               ALU selects, memory strobes, regfile write and PC update,
//               and traps on illegal opcodes.
//               Optional feature macro: MEM_TIMEOUT_EN - bounds imem/dmem
//               wait states by MEM_TIMEOUT cycles and traps on expiry.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_multicycle_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    input  logic       do_branch,
    output logic       imem_req,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_src,
    output logic [1:0] alu_op,
    output logic       alu_src,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] wb_sel,
    output logic       retire,
    output logic       trap,
    output logic [1:0] trap_cause
);

    state_t       r_state;
    instr_class_t r_cls;
    logic         r_trap;
    logic [1:0]   r_trap_cause;

    instr_class_t w_cls;
    logic         w_illegal;

`ifdef MEM_TIMEOUT_EN
    // Last wait-counter value at which a missing ready still counts as a wait
    localparam logic [TO_W-1:0] c_WAIT_LAST = TO_W'(MEM_TIMEOUT - 1);
    logic [TO_W-1:0] r_wait_cnt;
`else
    // Timeout parameters have no effect without the wait counter
    logic [TO_W-1:0] w_unused_timeout;
    assign w_unused_timeout = TO_W'(MEM_TIMEOUT);
`endif

    opcode_classifier u_classifier (
        .opcode  (opcode),
        .cls     (w_cls),
        .illegal (w_illegal)
    );

    // Sequencer state, latched instruction class, sticky trap and wait counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= ST_FETCH;
            r_cls        <= CLS_NONE;
            r_trap       <= 1'b0;
            r_trap_cause <= TRAP_NONE;
`ifdef MEM_TIMEOUT_EN
            r_wait_cnt   <= '0;
`endif
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (imem_ready) begin
                        r_state <= ST_DECODE;
`ifdef MEM_TIMEOUT_EN
                    end else if (r_wait_cnt == c_WAIT_LAST) begin
                        r_state      <= ST_TRAP;
                        r_trap       <= 1'b1;
                        r_trap_cause <= TRAP_IMEM_TO;
`endif
                    end
                end
                ST_DECODE: begin
                    if (w_illegal) begin
                        r_state      <= ST_TRAP;
                        r_trap       <= 1'b1;
                        r_trap_cause <= TRAP_ILLEGAL;
                    end else begin
                        r_cls   <= w_cls;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    case (r_cls)
                        CLS_BR:         r_state <= ST_FETCH;
                        CLS_LD, CLS_ST: r_state <= ST_MEM;
                        default:        r_state <= ST_WB;
                    endcase
                end
                ST_MEM: begin
                    if (dmem_ready) begin
                        r_state <= (r_cls == CLS_ST) ? ST_FETCH : ST_WB;
`ifdef MEM_TIMEOUT_EN
                    end else if (r_wait_cnt == c_WAIT_LAST) begin
                        r_state      <= ST_TRAP;
                        r_trap       <= 1'b1;
                        r_trap_cause <= TRAP_DMEM_TO;
`endif
                    end
                end
                ST_WB:   r_state <= ST_FETCH;
                default: r_state <= ST_TRAP;
            endcase
`ifdef MEM_TIMEOUT_EN
            // Count ready-less wait cycles; any other cycle leaves it at zero for the next wait state
            if ((r_state == ST_FETCH && !imem_ready) || (r_state == ST_MEM && !dmem_ready)) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end else begin
                r_wait_cnt <= '0;
            end
`endif
        end
    end

    // Moore decode of state and latched class; ready/do_branch only qualify the completing cycle.
    // While reset is asserted everything except the fetch request is forced low.
    always_comb begin
        imem_req   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        alu_op     = ALUOP_LDST;
        alu_src    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        wb_sel     = WB_ALU;
        retire     = 1'b0;
        trap       = r_trap;
        trap_cause = r_trap_cause;
        case (r_state)
            ST_FETCH: begin
                imem_req = 1'b1;
                ir_write = imem_ready;
            end
            ST_EXEC: begin
                alu_op  = alu_op_of(r_cls);
                alu_src = alu_src_of(r_cls);
                if (r_cls == CLS_BR) begin
                    pc_write = 1'b1;
                    pc_src   = do_branch;
                    retire   = 1'b1;
                end
            end
            ST_MEM: begin
                alu_op    = alu_op_of(r_cls);
                alu_src   = alu_src_of(r_cls);
                mem_read  = (r_cls == CLS_LD);
                mem_write = (r_cls == CLS_ST);
                if (r_cls == CLS_ST && dmem_ready) begin
                    pc_write = 1'b1;
                    retire   = 1'b1;
                end
            end
            ST_WB: begin
                alu_op    = alu_op_of(r_cls);
                alu_src   = alu_src_of(r_cls);
                reg_write = 1'b1;
                pc_write  = 1'b1;
                pc_src    = (r_cls == CLS_JAL);
                retire    = 1'b1;
                case (r_cls)
                    CLS_LD:  wb_sel = WB_LOAD;
                    CLS_JAL: wb_sel = WB_PC4;
                    default: wb_sel = WB_ALU;
                endcase
            end
            default: ;
        endcase
        if (!rst) begin
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            pc_src     = 1'b0;
            alu_op     = ALUOP_LDST;
            alu_src    = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            reg_write  = 1'b0;
            wb_sel     = WB_ALU;
            retire     = 1'b0;
            trap       = 1'b0;
            trap_cause = TRAP_NONE;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cpu_multicycle_sequencer.sv
// ============================================================================
// Module      : tb_cpu_multicycle_sequencer
// Description : Directed self-checking bench for cpu_multicycle_sequencer.
//               Each cycle drives ready/branch inputs, then compares the
//               packed output vector against a hand-computed value.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_multicycle_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic       imem_ready;
    logic       dmem_ready;
    logic       do_branch;
    logic       imem_req;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       retire;
    logic       trap;
    logic [1:0] trap_cause;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cpu_multicycle_sequencer #(
        .MEM_TIMEOUT (4),
        .TO_W        (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .do_branch  (do_branch),
        .imem_req   (imem_req),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .alu_op     (alu_op),
        .alu_src    (alu_src),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .wb_sel     (wb_sel),
        .retire     (retire),
        .trap       (trap),
        .trap_cause (trap_cause)
    );

    // Expected-vector builder, field order matches w_obs below
    function automatic logic [15:0] ov(input bit imq, input bit irw, input bit pcw, input bit pcs,
                                       input logic [1:0] aop, input bit asrc, input bit mr, input bit mw,
                                       input bit rw, input logic [1:0] wbs, input bit ret, input bit trp,
                                       input logic [1:0] cause);
        return {imq, irw, pcw, pcs, aop, asrc, mr, mw, rw, wbs, ret, trp, cause};
    endfunction

    logic [15:0] w_obs;
    assign w_obs = {imem_req, ir_write, pc_write, pc_src, alu_op, alu_src, mem_read, mem_write,
                    reg_write, wb_sel, retire, trap, trap_cause};

    localparam logic [15:0] c_IDLE   = 16'h0000;
    localparam logic [15:0] c_FETCH  = 16'h8000;
    localparam logic [15:0] c_FETCHR = 16'hC000;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %04h expected %04h", tag, got, exp);
        end
    endtask

    // One cycle: drive inputs just after the edge, compare mid-cycle, advance past the next edge
    task automatic cyc(input string tag, input bit ir, input bit dr, input bit db, input logic [15:0] exp);
        imem_ready = ir;
        dmem_ready = dr;
        do_branch  = db;
        #1;
        check(tag, w_obs, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b0;
        opcode     = 7'b0110011;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        do_branch  = 1'b0;
        @(posedge clk);
        #1;
        // Held in reset: only the fetch request, ready ignored
        cyc("rst fetch", 1, 1, 1, c_FETCH);
        cyc("rst ready ignored", 1, 0, 0, c_FETCH);
        rst = 1'b1;

        // R-type: retire on cycle 4
        opcode = 7'b0110011;
        cyc("R fetch", 1, 0, 0, c_FETCHR);
        cyc("R decode", 0, 0, 1, c_IDLE);
        cyc("R exec", 0, 0, 1, ov(0,0,0,0,2'b10,0,0,0,0,2'b00,0,0,2'b00));
        cyc("R wb", 0, 0, 0, ov(0,0,1,0,2'b10,0,0,0,1,2'b00,1,0,2'b00));

        // LD with three dmem wait states: retire on cycle 8
        opcode = 7'b0000011;
        cyc("LD fetch", 1, 0, 0, c_FETCHR);
        cyc("LD decode", 0, 0, 0, c_IDLE);
        cyc("LD exec", 0, 0, 0, ov(0,0,0,0,2'b00,1,0,0,0,2'b00,0,0,2'b00));
        cyc("LD mem1", 0, 0, 0, ov(0,0,0,0,2'b00,1,1,0,0,2'b00,0,0,2'b00));
        cyc("LD mem2", 0, 0, 0, ov(0,0,0,0,2'b00,1,1,0,0,2'b00,0,0,2'b00));
        cyc("LD mem3", 0, 0, 0, ov(0,0,0,0,2'b00,1,1,0,0,2'b00,0,0,2'b00));
        cyc("LD mem4", 0, 1, 0, ov(0,0,0,0,2'b00,1,1,0,0,2'b00,0,0,2'b00));
        cyc("LD wb", 0, 1, 0, ov(0,0,1,0,2'b00,1,0,0,1,2'b01,1,0,2'b00));

        // Branch taken, then not taken
        opcode = 7'b1100011;
        cyc("BR fetch wait", 0, 0, 0, c_FETCH);
        cyc("BR fetch", 1, 0, 0, c_FETCHR);
        cyc("BR decode", 0, 0, 0, c_IDLE);
        cyc("BR taken", 0, 0, 1, ov(0,0,1,1,2'b01,0,0,0,0,2'b00,1,0,2'b00));
        cyc("BR fetch2", 1, 0, 0, c_FETCHR);
        cyc("BR decode2", 0, 0, 0, c_IDLE);
        cyc("BR not taken", 0, 0, 0, ov(0,0,1,0,2'b01,0,0,0,0,2'b00,1,0,2'b00));

        // Store with ready on first MEM cycle
        opcode = 7'b0100011;
        cyc("ST fetch", 1, 0, 0, c_FETCHR);
        cyc("ST decode", 0, 0, 0, c_IDLE);
        cyc("ST exec", 0, 0, 0, ov(0,0,0,0,2'b00,1,0,0,0,2'b00,0,0,2'b00));
        cyc("ST mem", 0, 1, 0, ov(0,0,1,0,2'b00,1,0,1,0,2'b00,1,0,2'b00));

        // JAL writes PC+4 and jumps
        opcode = 7'b1101111;
        cyc("JAL fetch", 1, 0, 0, c_FETCHR);
        cyc("JAL decode", 0, 0, 0, c_IDLE);
        cyc("JAL exec", 0, 0, 0, ov(0,0,0,0,2'b00,1,0,0,0,2'b00,0,0,2'b00));
        cyc("JAL wb", 0, 0, 0, ov(0,0,1,1,2'b00,1,0,0,1,2'b10,1,0,2'b00));

        // I-arith
        opcode = 7'b0010011;
        cyc("I fetch", 1, 0, 0, c_FETCHR);
        cyc("I decode", 0, 0, 0, c_IDLE);
        cyc("I exec", 0, 0, 0, ov(0,0,0,0,2'b11,1,0,0,0,2'b00,0,0,2'b00));
        cyc("I wb", 0, 0, 0, ov(0,0,1,0,2'b11,1,0,0,1,2'b00,1,0,2'b00));

        // Store abandoned by reset while dmem_ready arrives
        opcode = 7'b0100011;
        cyc("STR fetch", 1, 0, 0, c_FETCHR);
        cyc("STR decode", 0, 0, 0, c_IDLE);
        cyc("STR exec", 0, 0, 0, ov(0,0,0,0,2'b00,1,0,0,0,2'b00,0,0,2'b00));
        cyc("STR mem wait", 0, 0, 0, ov(0,0,0,0,2'b00,1,0,1,0,2'b00,0,0,2'b00));
        rst = 1'b0;
        cyc("STR rst in mem", 0, 1, 0, c_IDLE);
        cyc("STR after rst", 0, 1, 0, c_FETCH);
        rst = 1'b1;
        cyc("STR released", 0, 1, 0, c_FETCH);

        // Illegal opcode traps and ignores everything until reset
        opcode = 7'b1111111;
        cyc("ILL fetch", 1, 0, 0, c_FETCHR);
        cyc("ILL decode", 0, 0, 0, c_IDLE);
        cyc("ILL trap", 1, 1, 1, ov(0,0,0,0,2'b00,0,0,0,0,2'b00,0,1,2'b01));
        cyc("ILL trap hold", 1, 0, 1, ov(0,0,0,0,2'b00,0,0,0,0,2'b00,0,1,2'b01));
        cyc("ILL trap hold2", 0, 1, 0, ov(0,0,0,0,2'b00,0,0,0,0,2'b00,0,1,2'b01));
        rst = 1'b0;
        cyc("ILL rst low", 0, 0, 0, c_IDLE);
        cyc("ILL after rst", 0, 0, 0, c_FETCH);
        rst = 1'b1;

`ifdef MEM_TIMEOUT_EN
        // imem never ready: four wait cycles then trap cause 10
        opcode = 7'b0110011;
        cyc("TO wait1", 0, 0, 0, c_FETCH);
        cyc("TO wait2", 0, 0, 0, c_FETCH);
        cyc("TO wait3", 0, 0, 0, c_FETCH);
        cyc("TO wait4", 0, 0, 0, c_FETCH);
        cyc("TO trap", 1, 0, 0, ov(0,0,0,0,2'b00,0,0,0,0,2'b00,0,1,2'b10));
        rst = 1'b0;
        cyc("TO rst", 0, 0, 0, c_IDLE);
        rst = 1'b1;
        // Ready on the terminal cycle beats the timeout
        cyc("TOR wait1", 0, 0, 0, c_FETCH);
        cyc("TOR wait2", 0, 0, 0, c_FETCH);
        cyc("TOR wait3", 0, 0, 0, c_FETCH);
        cyc("TOR ready4", 1, 0, 0, c_FETCHR);
        cyc("TOR decode", 0, 0, 0, c_IDLE);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
